pmem_line_responder: RTL and testbench



---
 rtl/pmem_line_responder_pkg.sv | 21 ++
 rtl/pmem_line_responder_beat_counter.sv | 26 ++
 rtl/pmem_line_responder.sv | 134 +++++++++++++
 tb/tb_pmem_line_responder.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the pmem line responder: line/beat geometry and FSM states.
package pmem_line_responder_pkg;

    localparam int unsigned C2_LINE_BITS = 256;
    localparam int unsigned C2_BEAT_BITS = 64;
    localparam int unsigned C2_ADDR_BITS = 16;

    localparam int unsigned C2_BEATS_PER_LINE   = C2_LINE_BITS / C2_BEAT_BITS;
    localparam int unsigned C2_LINE_OFFSET_BITS = $clog2(C2_LINE_BITS / 8);

    typedef logic [C2_BEAT_BITS-1:0] lc3b_c2_beat;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StRdata,
        StResp
    } resp_state_e;

endpackage

// File: rtl/pmem_line_responder_beat_counter.sv
// Beat index within a line burst: clear, increment with wrap, and last-beat flag.
module line_beat_counter #(
    parameter int unsigned  BEATS = 4,
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          incr,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pmem_line_responder.sv
// Turns held full-line pmem read/write requests into beat-serial ready/valid bursts and
// acknowledges with a one-cycle pmem_resp only if the same request is still being asked for.
module pmem_line_responder
    import pmem_line_responder_pkg::*;
#(
    parameter int unsigned LINE_BITS = C2_LINE_BITS,
    parameter int unsigned BEAT_BITS = C2_BEAT_BITS,
    parameter int unsigned ADDR_BITS = C2_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [ADDR_BITS-1:0] pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic                 pmem_resp,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 burst_cmd_valid,
    input  logic                 burst_cmd_ready,
    output logic                 burst_cmd_write,
    output logic [ADDR_BITS-1:0] burst_addr,
    output logic [BEAT_BITS-1:0] burst_wdata,
    output logic                 burst_wvalid,
    input  logic                 burst_wready,
    input  logic [BEAT_BITS-1:0] burst_rdata,
    input  logic                 burst_rvalid
);

    localparam int unsigned BEATS = LINE_BITS / BEAT_BITS;
    localparam int unsigned OFF   = $clog2(LINE_BITS / 8);
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    resp_state_e state_q, state_d;
    logic        capture;

    logic                            write_q;
    logic [ADDR_BITS-1:OFF]          addr_q;
    logic [BEATS-1:0][BEAT_BITS-1:0] wdata_q;
    logic [BEATS-1:0][BEAT_BITS-1:0] rdata_q;

    logic [CW-1:0] beat_idx;
    logic          last_beat;
    logic          beat_fire;
    logic          req_match;

    logic unused_addr_offset;
    assign unused_addr_offset = ^pmem_address[OFF-1:0];

    assign beat_fire = ((state_q == StWdata) && burst_wready) ||
                       ((state_q == StRdata) && burst_rvalid);

    // The requester may have withdrawn or retargeted mid-burst; only ack an unchanged request.
    assign req_match = (write_q ? pmem_write : pmem_read) &&
                       (pmem_address[ADDR_BITS-1:OFF] == addr_q);

    line_beat_counter #(
        .BEATS (BEATS)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == StIdle),
        .incr  (beat_fire),
        .count (beat_idx),
        .last  (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pmem_write || pmem_read) begin
                    capture = 1'b1;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (burst_cmd_ready) begin
                    state_d = write_q ? StWdata : StRdata;
                end
            end
            StWdata, StRdata: begin
                if (beat_fire && last_beat) begin
                    state_d = req_match ? StResp : StIdle;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            write_q <= pmem_write;
            addr_q  <= pmem_address[ADDR_BITS-1:OFF];
            if (pmem_write) begin
                wdata_q <= pmem_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if ((state_q == StRdata) && burst_rvalid) begin
            rdata_q[beat_idx] <= burst_rdata;
        end
    end

    assign pmem_resp       = (state_q == StResp);
    assign pmem_rdata      = rdata_q;
    assign burst_cmd_valid = (state_q == StCmd);
    assign burst_cmd_write = write_q;
    assign burst_addr      = {addr_q, {OFF{1'b0}}};
    assign burst_wvalid    = (state_q == StWdata);
    assign burst_wdata     = wdata_q[beat_idx];

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: a reactive burst memory plus a line-level reference model.
module tb_pmem_line_responder;

    localparam int LB = 256;
    localparam int BB = 64;
    localparam int NB = LB / BB;

    typedef enum int {MNone, MRead, MWrite} mmode_e;

    logic          clk;
    logic          rst_n;
    logic          pmem_read, pmem_write;
    logic [15:0]   pmem_address;
    logic [LB-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LB-1:0] pmem_rdata;
    logic          burst_cmd_valid, burst_cmd_ready, burst_cmd_write;
    logic [15:0]   burst_addr;
    logic [BB-1:0] burst_wdata, burst_rdata;
    logic          burst_wvalid, burst_wready, burst_rvalid;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory-side knobs (written by the test sequence) and observations (written by the memory).
    int rd_stall_pct = 0, wr_stall_pct = 0, cmd_stall_pct = 0;
    bit noise_en = 0;
    int force_beat = -1, force_cycles = 0;
    mmode_e mmode = MNone;
    int mbeat = 0;
    int stall_err = 0, wvalid_err = 0, stall_cycles = 0, resp_count = 0;
    logic [15:0]   cmd_addr_q[$];
    logic          cmd_wr_q[$];
    logic [LB-1:0] phys[int];
    logic [LB-1:0] ref_mem[int];
    logic [LB-1:0] last_rd = '0;

    pmem_line_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .burst_cmd_valid (burst_cmd_valid),
        .burst_cmd_ready (burst_cmd_ready),
        .burst_cmd_write (burst_cmd_write),
        .burst_addr      (burst_addr),
        .burst_wdata     (burst_wdata),
        .burst_wvalid    (burst_wvalid),
        .burst_wready    (burst_wready),
        .burst_rdata     (burst_rdata),
        .burst_rvalid    (burst_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] align(input logic [15:0] a);
        return {a[15:5], 5'b0};
    endfunction

    function automatic logic [LB-1:0] init_line(input logic [15:0] a);
        logic [LB-1:0] l;
        for (int k = 0; k < NB; k++) l[k*BB +: BB] = {a, 16'(k), 32'h5A5A_0000 | 32'(a)};
        return l;
    endfunction

    function automatic logic [LB-1:0] phys_get(input logic [15:0] a);
        return phys.exists(int'(a)) ? phys[int'(a)] : init_line(a);
    endfunction

    function automatic logic [LB-1:0] ref_get(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_line(a);
    endfunction

    function automatic logic [LB-1:0] rand_line();
        logic [LB-1:0] l;
        for (int k = 0; k < LB / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // Responding memory: decides its inputs at each falling edge for the next rising edge.
    initial begin
        logic [LB-1:0] line, wline;
        logic [15:0]   maddr;
        logic [BB-1:0] stall_val;
        bit            stall_prev, go;
        int            force_left;
        burst_cmd_ready = 0; burst_wready = 0; burst_rvalid = 0; burst_rdata = '0;
        maddr = '0; wline = '0; stall_val = '0; stall_prev = 0; force_left = 0;
        forever begin
            @(negedge clk);
            burst_cmd_ready = 0; burst_wready = 0; burst_rvalid = 0;
            if (!rst_n) begin
                mmode = MNone; mbeat = 0; stall_prev = 0;
                continue;
            end
            case (mmode)
                MRead: begin
                    if (($urandom % 100) >= rd_stall_pct) begin
                        line = phys_get(maddr);
                        burst_rvalid = 1;
                        burst_rdata = line[mbeat*BB +: BB];
                        mbeat++;
                        if (mbeat == NB) mmode = MNone;
                    end
                end
                MWrite: begin
                    if (!burst_wvalid) wvalid_err++;
                    if (stall_prev && burst_wdata !== stall_val) stall_err++;
                    go = ($urandom % 100) >= wr_stall_pct;
                    if (force_beat == mbeat && force_left > 0) begin
                        go = 0;
                        force_left--;
                    end
                    if (go) begin
                        burst_wready = 1;
                        wline[mbeat*BB +: BB] = burst_wdata;
                        mbeat++;
                        stall_prev = 0;
                        if (mbeat == NB) begin
                            phys[int'(maddr)] = wline;
                            mmode = MNone;
                        end
                    end else begin
                        stall_prev = 1;
                        stall_val = burst_wdata;
                        stall_cycles++;
                    end
                end
                default: begin
                    if (noise_en && ($urandom % 3) == 0) begin
                        burst_rvalid = 1;
                        burst_rdata = {$urandom, $urandom};
                    end
                end
            endcase
            if (burst_cmd_valid && mmode == MNone && ($urandom % 100) >= cmd_stall_pct) begin
                burst_cmd_ready = 1;
                cmd_addr_q.push_back(burst_addr);
                cmd_wr_q.push_back(burst_cmd_write);
                maddr = burst_addr;
                mmode = burst_cmd_write ? MWrite : MRead;
                mbeat = 0;
                stall_prev = 0;
                force_left = force_cycles;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (pmem_resp) resp_count++;
    end

    task automatic do_req(input logic wr, input logic rd, input logic [15:0] a,
                          input logic [LB-1:0] wd, input bit hold, output int lat);
        @(negedge clk); #2;
        pmem_write = wr; pmem_read = rd; pmem_address = a; pmem_wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!pmem_resp && lat < 200);
        if (!pmem_resp) lat = -1;
        #2;
        if (!hold) begin
            pmem_write = 0; pmem_read = 0;
        end
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({pmem_resp, burst_cmd_valid, burst_cmd_write, burst_wvalid} !== 4'b0)
            $display("FAIL reset_ctrl: got %b want 0000",
                     {pmem_resp, burst_cmd_valid, burst_cmd_write, burst_wvalid});
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== '0) $display("FAIL reset_rdata: got %h want 0", pmem_rdata);
        else n_pass++;
        n_checks++;
        if ({burst_addr, burst_wdata} !== '0)
            $display("FAIL reset_addr_wdata: got %h/%h want 0/0", burst_addr, burst_wdata);
        else n_pass++;
        @(negedge clk); #2;
        rst_n = 1;
    endtask

    task automatic test_read();
        logic [LB-1:0] l;
        int lat, r0;
        l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        phys[16'h1220] = l;
        ref_mem[16'h1220] = l;
        r0 = resp_count;
        do_req(1'b0, 1'b1, 16'h1234, '0, 0, lat);
        n_checks++;
        // Request cycle plus six edges: the pulse lands in the 7th cycle.
        if (lat !== 6) $display("FAIL read_latency: got %0d want 6", lat);
        else n_pass++;
        n_checks++;
        if (cmd_addr_q.size() == 0 || cmd_addr_q[$] !== 16'h1220 || cmd_wr_q[$] !== 1'b0)
            $display("FAIL read_cmd: got %h/%b want 1220/0",
                     cmd_addr_q.size() ? cmd_addr_q[$] : 16'hx, cmd_wr_q.size() ? cmd_wr_q[$] : 1'bx);
        else n_pass++;
        n_checks++;
        if (resp_count - r0 !== 1) $display("FAIL read_resp_count: got %0d want 1", resp_count - r0);
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== l) $display("FAIL read_data: got %h want %h", pmem_rdata, l);
        else n_pass++;
        last_rd = l;
    endtask

    task automatic test_write_stall();
        logic [LB-1:0] a;
        int lat, r0, s0, e0, w0;
        a = rand_line();
        r0 = resp_count; s0 = stall_cycles; e0 = stall_err; w0 = wvalid_err;
        force_beat = 2; force_cycles = 3;
        do_req(1'b1, 1'b0, 16'h0040, a, 0, lat);
        force_beat = -1; force_cycles = 0;
        ref_mem[16'h0040] = a;
        n_checks++;
        if (lat !== 9) $display("FAIL write_latency: got %0d want 9", lat);
        else n_pass++;
        n_checks++;
        if (cmd_addr_q[$] !== 16'h0040 || cmd_wr_q[$] !== 1'b1)
            $display("FAIL write_cmd: got %h/%b want 0040/1", cmd_addr_q[$], cmd_wr_q[$]);
        else n_pass++;
        n_checks++;
        if (phys_get(16'h0040) !== a)
            $display("FAIL write_beats: got %h want %h", phys_get(16'h0040), a);
        else n_pass++;
        n_checks++;
        if (stall_cycles - s0 !== 3 || stall_err - e0 !== 0 || wvalid_err - w0 !== 0)
            $display("FAIL write_stall_hold: stalls %0d unstable %0d novalid %0d want 3/0/0",
                     stall_cycles - s0, stall_err - e0, wvalid_err - w0);
        else n_pass++;
        n_checks++;
        if (resp_count - r0 !== 1) $display("FAIL write_resp_count: got %0d want 1", resp_count - r0);
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== last_rd) $display("FAIL write_rdata_kept: got %h want %h", pmem_rdata, last_rd);
        else n_pass++;
    endtask

    task automatic test_withdraw();
        logic [LB-1:0] b;
        int c0, r0, k;
        b = rand_line();
        c0 = cmd_addr_q.size(); r0 = resp_count;
        @(negedge clk); #2;
        pmem_write = 1; pmem_read = 0; pmem_address = 16'h0040; pmem_wdata = b;
        k = 0;
        while (cmd_addr_q.size() == c0 && k < 50) begin
            @(negedge clk); #2; k++;
        end
        @(negedge clk); #2;
        pmem_write = 0; pmem_read = 1; pmem_address = 16'h0086;
        k = 0;
        do begin
            @(negedge clk); k++;
        end while (!pmem_resp && k < 200);
        n_checks++;
        if (!pmem_resp) $display("FAIL withdraw_timeout: got no resp want resp");
        else n_pass++;
        #2;
        pmem_read = 0;
        ref_mem[16'h0040] = b;
        n_checks++;
        if (cmd_addr_q.size() - c0 !== 2 || resp_count - r0 !== 1)
            $display("FAIL withdraw_counts: cmds %0d resps %0d want 2/1",
                     cmd_addr_q.size() - c0, resp_count - r0);
        else n_pass++;
        n_checks++;
        if (cmd_addr_q.size() < c0 + 2 ||
            {cmd_addr_q[c0], cmd_wr_q[c0], cmd_addr_q[c0+1], cmd_wr_q[c0+1]} !==
            {16'h0040, 1'b1, 16'h0080, 1'b0})
            $display("FAIL withdraw_cmd_order: got %0d cmds want 0040/w then 0080/r",
                     cmd_addr_q.size() - c0);
        else n_pass++;
        n_checks++;
        if (phys_get(16'h0040) !== b) $display("FAIL withdraw_write_data: got %h want %h",
                                               phys_get(16'h0040), b);
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== ref_get(16'h0080))
            $display("FAIL withdraw_read_data: got %h want %h", pmem_rdata, ref_get(16'h0080));
        else n_pass++;
        last_rd = ref_get(16'h0080);
    endtask

    task automatic test_both();
        logic [LB-1:0] c;
        int lat, r0;
        c = rand_line();
        r0 = resp_count;
        do_req(1'b1, 1'b1, 16'h0100, c, 0, lat);
        ref_mem[16'h0100] = c;
        n_checks++;
        if (lat !== 6 || resp_count - r0 !== 1)
            $display("FAIL both_resp: lat %0d resps %0d want 6/1", lat, resp_count - r0);
        else n_pass++;
        n_checks++;
        if (cmd_wr_q[$] !== 1'b1 || cmd_addr_q[$] !== 16'h0100)
            $display("FAIL both_cmd: got %h/%b want 0100/1", cmd_addr_q[$], cmd_wr_q[$]);
        else n_pass++;
        n_checks++;
        if (phys_get(16'h0100) !== c) $display("FAIL both_data: got %h want %h",
                                               phys_get(16'h0100), c);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, r0, c0;
        r0 = resp_count; c0 = cmd_addr_q.size();
        do_req(1'b0, 1'b1, 16'h002A, '0, 1, lat1);
        lat2 = 0;
        do begin
            @(negedge clk); lat2++;
        end while (!pmem_resp && lat2 < 200);
        #2;
        pmem_read = 0;
        repeat (4) @(negedge clk);
        #2;
        n_checks++;
        if (lat1 !== 6 || lat2 !== 7)
            $display("FAIL b2b_latency: got %0d/%0d want 6/7", lat1, lat2);
        else n_pass++;
        n_checks++;
        if (resp_count - r0 !== 2 || cmd_addr_q.size() - c0 !== 2)
            $display("FAIL b2b_counts: resps %0d cmds %0d want 2/2",
                     resp_count - r0, cmd_addr_q.size() - c0);
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== ref_get(16'h0020))
            $display("FAIL b2b_data: got %h want %h", pmem_rdata, ref_get(16'h0020));
        else n_pass++;
        last_rd = ref_get(16'h0020);
    endtask

    task automatic test_reset_mid_burst();
        int k, lat, r0;
        @(negedge clk); #2;
        pmem_read = 1; pmem_write = 0; pmem_address = 16'h0311;
        k = 0;
        do begin
            @(negedge clk); #2; k++;
        end while (!(mmode == MRead && mbeat == 3) && k < 40);
        n_checks++;
        if (!(mmode == MRead && mbeat == 3)) $display("FAIL rst_reach_beat2: got beat %0d want 3", mbeat);
        else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if ({pmem_resp, burst_cmd_valid, burst_cmd_write, burst_wvalid, burst_addr, burst_wdata} !== '0)
            $display("FAIL rst_async_outputs: got addr %h ctrl %b want 0", burst_addr,
                     {pmem_resp, burst_cmd_valid, burst_cmd_write, burst_wvalid});
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== '0) $display("FAIL rst_async_rdata: got %h want 0", pmem_rdata);
        else n_pass++;
        pmem_read = 0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1;
        last_rd = '0;
        r0 = resp_count;
        do_req(1'b0, 1'b1, 16'h0300, '0, 0, lat);
        n_checks++;
        if (lat !== 6 || resp_count - r0 !== 1)
            $display("FAIL rst_fresh_read: lat %0d resps %0d want 6/1", lat, resp_count - r0);
        else n_pass++;
        n_checks++;
        if (pmem_rdata !== ref_get(16'h0300))
            $display("FAIL rst_fresh_data: got %h want %h", pmem_rdata, ref_get(16'h0300));
        else n_pass++;
        last_rd = ref_get(16'h0300);
    endtask

    task automatic test_random();
        logic [15:0]   pool[5] = '{16'h0000, 16'h0020, 16'h0040, 16'h1220, 16'h3FE0};
        logic [15:0]   a, al;
        logic [LB-1:0] wd;
        logic          wr, both;
        int lat, r0, c0, e0;
        noise_en = 1;
        for (int t = 0; t < 24; t++) begin
            rd_stall_pct = $urandom_range(0, 50);
            wr_stall_pct = $urandom_range(0, 50);
            cmd_stall_pct = $urandom_range(0, 50);
            wr = 1'($urandom % 2);
            both = wr && (($urandom % 4) == 0);
            a = pool[$urandom % 5] | 16'($urandom % 32);
            al = align(a);
            wd = rand_line();
            r0 = resp_count; c0 = cmd_addr_q.size(); e0 = stall_err + wvalid_err;
            do_req(wr, !wr || both, a, wd, 0, lat);
            n_checks++;
            if (lat < 0 || resp_count - r0 !== 1)
                $display("FAIL rand%0d_resp: lat %0d resps %0d want 1 resp", t, lat, resp_count - r0);
            else n_pass++;
            n_checks++;
            if (cmd_addr_q.size() - c0 !== 1 || cmd_addr_q[$] !== al || cmd_wr_q[$] !== wr)
                $display("FAIL rand%0d_cmd: got %h/%b want %h/%b", t, cmd_addr_q[$], cmd_wr_q[$], al, wr);
            else n_pass++;
            if (wr) begin
                ref_mem[int'(al)] = wd;
                n_checks++;
                if (phys_get(al) !== wd || stall_err + wvalid_err - e0 !== 0)
                    $display("FAIL rand%0d_wdata: got %h want %h", t, phys_get(al), wd);
                else n_pass++;
                n_checks++;
                if (pmem_rdata !== last_rd)
                    $display("FAIL rand%0d_rdata_kept: got %h want %h", t, pmem_rdata, last_rd);
                else n_pass++;
            end else begin
                n_checks++;
                if (pmem_rdata !== ref_get(al))
                    $display("FAIL rand%0d_rdata: got %h want %h", t, pmem_rdata, ref_get(al));
                else n_pass++;
                last_rd = ref_get(al);
            end
        end
        noise_en = 0;
        rd_stall_pct = 0; wr_stall_pct = 0; cmd_stall_pct = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 0;
        pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
        test_reset();
        test_read();
        test_write_stall();
        test_withdraw();
        test_both();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
